vdc_pair_sched: RTL and testbench

Scheduler that time-shares one `vdcorput_fsm_32bit_simple` engine to generate a sequence of 2-D low-discrepancy point pairs (x = VdC(k, base0), y = VdC(k, base1)) for the disk/circle generators. It sits between a configuration/host side and the single engine instance. It sequences start/k/base_sel per index, captures the 16.16 results, and delivers each (x, y, k) triple on a valid/ready output stream. Two engines are replaced by one plus this controller.

---
 rtl/vdc_pair_sched.sv | 202 ++++++++++++++++++++
 tb/tb_vdc_pair_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_pair_sched.sv
// vdc_pair_sched: time-shares one VdC engine to produce (x, y, k) point pairs.
// For each index k the engine is run twice, first with base0 (result -> out_x) and
// then with base1 (result -> out_y). The triple is then offered on a valid/ready stream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   run, abort               start pulse (sampled in idle), level abort
//   cfg_k_start, cfg_count   first index and number of pairs, latched on run
//   cfg_base0, cfg_base1     engine base_sel for x and y, latched on run
//   busy, seq_done, error    status; error is the sticky watchdog flag
//   eng_*                    single engine handshake (start/k/base_sel out, result/done/ready in)
//   out_valid/out_ready      output stream carrying out_x, out_y, out_k
//
// Optional macro VDC_SCHED_TIMEOUT_EN: adds a watchdog of TIMEOUT_CYCLES cycles on the
// engine wait states. Without it error is tied low and the waits are unbounded.
module vdc_pair_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        abort,
  input  logic [31:0] cfg_k_start,
  input  logic [15:0] cfg_count,
  input  logic [1:0]  cfg_base0,
  input  logic [1:0]  cfg_base1,
  output logic        busy,
  output logic        seq_done,
  output logic        error,
  output logic        eng_start,
  output logic [31:0] eng_k,
  output logic [1:0]  eng_base_sel,
  input  logic [31:0] eng_result,
  input  logic        eng_done,
  input  logic        eng_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_k
);

  typedef enum logic [2:0] {
    StIdle, StRdy0, StWait0, StRdy1, StWait1, StEmit, StDrain
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] k_q, k_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0]  base0_q, base0_d, base1_q, base1_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic        done_q, done_d;
  logic        timeout;
  logic        timeout_hit;
  logic        run_accept;

  assign run_accept = (state_q == StIdle) && run;

`ifdef VDC_SCHED_TIMEOUT_EN
  logic [31:0] timer_q;
  logic        err_q;
  logic        waiting;

  assign waiting = (state_q == StWait0) || (state_q == StWait1) || (state_q == StDrain);
  // Fires on the TIMEOUT_CYCLES-th cycle spent in the current wait state.
  assign timeout = waiting && (({1'b0, timer_q} + 33'd1) >= 33'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_d != state_q) timer_q <= '0;
      else if (waiting)       timer_q <= timer_q + 32'd1;
      if (run_accept)        err_q <= 1'b0;
      else if (timeout_hit)  err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign error      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rem_d       = rem_q;
    base0_d     = base0_q;
    base1_d     = base1_q;
    x_d         = x_q;
    y_d         = y_q;
    done_d      = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        // abort has no effect here, so run wins a tie.
        if (run) begin
          if (cfg_count == 16'd0) begin
            done_d = 1'b1;
          end else begin
            k_d     = cfg_k_start;
            rem_d   = cfg_count;
            base0_d = cfg_base0;
            base1_d = cfg_base1;
            state_d = StRdy0;
          end
        end
      end
      StRdy0, StRdy1: begin
        if (abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (eng_ready) begin
          state_d = (state_q == StRdy0) ? StWait0 : StWait1;
        end
      end
      StWait0, StWait1: begin
        if (eng_done) begin
          if (abort) begin
            // Done already arrived, nothing left to drain.
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (state_q == StWait0) begin
            x_d     = eng_result;
            state_d = StRdy1;
          end else begin
            y_d     = eng_result;
            state_d = StEmit;
          end
        end else if (timeout) begin
          timeout_hit = 1'b1;
          state_d     = StIdle;
          done_d      = 1'b1;
        end else if (abort) begin
          state_d = StDrain;
        end
      end
      StEmit: begin
        if (abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (out_ready) begin
          k_d   = k_q + 32'd1;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRdy0;
          end
        end
      end
      StDrain: begin
        // Swallow the outstanding done so a later run cannot capture it.
        if (eng_done || timeout) begin
          timeout_hit = !eng_done;
          state_d     = StIdle;
          done_d      = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      rem_q   <= '0;
      base0_q <= '0;
      base1_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
      base0_q <= base0_d;
      base1_q <= base1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign seq_done     = done_q;
  assign eng_k        = k_q;
  assign eng_base_sel = ((state_q == StRdy1) || (state_q == StWait1)) ? base1_q : base0_q;
  // Abort suppresses the start so the engine is never left running unobserved.
  assign eng_start    = ((state_q == StRdy0) || (state_q == StRdy1)) && eng_ready && !abort;
  assign out_valid    = (state_q == StEmit) && !abort;
  assign out_x        = x_q;
  assign out_y        = y_q;
  assign out_k        = k_q;

endmodule

// File: tb/tb_vdc_pair_sched.sv
module tb_vdc_pair_sched;
  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, abort;
  logic [31:0] cfg_k_start;
  logic [15:0] cfg_count;
  logic [1:0]  cfg_base0, cfg_base1;
  logic        busy, seq_done, error;
  logic        eng_start;
  logic [31:0] eng_k;
  logic [1:0]  eng_base_sel;
  logic [31:0] eng_result;
  logic        eng_done, eng_ready;
  logic        out_valid, out_ready;
  logic [31:0] out_x, out_y, out_k;

  always #5 clk = ~clk;

  vdc_pair_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort),
    .cfg_k_start(cfg_k_start), .cfg_count(cfg_count),
    .cfg_base0(cfg_base0), .cfg_base1(cfg_base1),
    .busy(busy), .seq_done(seq_done), .error(error),
    .eng_start(eng_start), .eng_k(eng_k), .eng_base_sel(eng_base_sel),
    .eng_result(eng_result), .eng_done(eng_done), .eng_ready(eng_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_k(out_k)
  );

  int vec_n  = 0;
  int miss_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  // Radical inverse of k in the selected base, truncated to 16.16.
  function automatic logic [31:0] vdc(input logic [31:0] k, input logic [1:0] sel);
    longint unsigned b, n, d, kk;
    kk = 64'(k);
    n  = 0;
    d  = 1;
    case (sel)
      2'd0:    b = 2;
      2'd1:    b = 3;
      2'd2:    b = 5;
      default: b = 7;
    endcase
    while (kk != 0) begin
      n  = n * b + kk % b;
      d  = d * b;
      kk = kk / b;
    end
    return 32'((n << 16) / d);
  endfunction

  // Stub engine: fixed latency, ready while idle, optional never-done mode.
  int          lat        = 3;
  logic        hold_ready = 1'b0;
  logic        never_done = 1'b0;
  logic        s_busy;
  int          s_cnt;
  logic [31:0] s_k;
  logic [1:0]  s_b;

  assign eng_ready = !s_busy && !hold_ready;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (rst) begin
      s_busy     <= 1'b0;
      s_cnt      <= 0;
      eng_result <= '0;
    end else if (s_busy) begin
      if (s_cnt <= 1) begin
        s_busy     <= 1'b0;
        eng_done   <= 1'b1;
        eng_result <= vdc(s_k, s_b);
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end else if (eng_start && !never_done) begin
      s_busy <= 1'b1;
      s_cnt  <= lat;
      s_k    <= eng_k;
      s_b    <= eng_base_sel;
    end
  end

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] k;
  } trip_t;

  trip_t expq[$];
  trip_t acc[$];
  int    start_cnt = 0, done_cnt = 0, eng_done_cnt = 0;
  logic  prev_start = 1'b0;
  logic  done_due   = 1'b0;

  task automatic push_seq(input logic [31:0] k0, input int cnt, input logic [1:0] b0,
                          input logic [1:0] b1);
    logic [31:0] k;
    for (int i = 0; i < cnt; i++) begin
      k = k0 + 32'(i);
      expq.push_back('{x: vdc(k, b0), y: vdc(k, b1), k: k});
    end
  endtask

  // Compare process: scoreboard on the output stream plus engine-side protocol checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start) begin
        start_cnt++;
        chk("start_needs_ready", 32'(eng_ready), 32'd1);
        chk("start_back_to_back", 32'(prev_start), 32'd0);
      end
      prev_start = eng_start;
      if (s_busy) begin
        chk("eng_k_hold", eng_k, s_k);
        chk("eng_base_hold", 32'(eng_base_sel), 32'(s_b));
      end
      if (done_due) begin
        chk("seq_done_after_last", 32'(seq_done), 32'd1);
        chk("busy_after_last", 32'(busy), 32'd0);
        done_due = 1'b0;
      end
      if (seq_done) done_cnt++;
      if (eng_done) eng_done_cnt++;
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_x", out_x, expq[0].x);
          chk("out_y", out_y, expq[0].y);
          chk("out_k", out_k, expq[0].k);
          if (out_ready) begin
            acc.push_back(expq.pop_front());
            if (expq.size() == 0) done_due = 1'b1;
          end
        end
      end
    end
  end

  task automatic drive_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_seq(input logic [31:0] k0, input int cnt, input logic [1:0] b0,
                         input logic [1:0] b1);
    push_seq(k0, cnt, b0, b1);
    drive_tick();
    cfg_k_start = k0;
    cfg_count   = 16'(cnt);
    cfg_base0   = b0;
    cfg_base1   = b1;
    run         = 1'b1;
    drive_tick();
    run         = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      sample_tick();
      if (!busy && expq.size() == 0 && !done_due) break;
    end
    if (i == max) chk("idle_timeout", 32'(expq.size()) + 32'(busy), 32'd0);
  endtask

  int s0, d0, e0;

  initial begin
    rst = 1'b1; run = 1'b0; abort = 1'b0; out_ready = 1'b1;
    cfg_k_start = '0; cfg_count = '0; cfg_base0 = '0; cfg_base1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sample_tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq_done", 32'(seq_done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_eng_k", eng_k, 32'd0);
    chk("rst_eng_base", 32'(eng_base_sel), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_x", out_x, 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_out_k", out_k, 32'd0);

    // Bases 2/3, k=1, two pairs, no backpressure.
    d0 = done_cnt;
    run_seq(32'd1, 2, 2'd0, 2'd1);
    sample_tick();
    chk("busy_after_run", 32'(busy), 32'd1);
    wait_idle(200);
    chk("pairs_k1", 32'(acc.size()), 32'd2);
    if (acc.size() >= 2) begin
      chk("lit_x0", acc[0].x, 32'h0000_8000);
      chk("lit_y0", acc[0].y, 32'h0000_5555);
      chk("lit_k0", acc[0].k, 32'd1);
      chk("lit_x1", acc[1].x, 32'h0000_4000);
      chk("lit_y1", acc[1].y, 32'h0000_AAAA);
      chk("lit_k1", acc[1].k, 32'd2);
    end
    chk("done_pulses_k1", 32'(done_cnt - d0), 32'd1);

    // Backpressure: hold out_ready low for 20 cycles once a triple is offered.
    acc.delete();
    drive_tick();
    out_ready = 1'b0;
    run_seq(32'd1, 2, 2'd0, 2'd1);
    for (int i = 0; i < 100; i++) begin
      sample_tick();
      if (out_valid) break;
    end
    chk("valid_reached", 32'(out_valid), 32'd1);
    s0 = start_cnt;
    repeat (20) sample_tick();
    chk("no_start_while_stalled", 32'(start_cnt - s0), 32'd0);
    chk("valid_held", 32'(out_valid), 32'd1);
    drive_tick();
    out_ready = 1'b1;
    wait_idle(200);
    chk("pairs_stall", 32'(acc.size()), 32'd2);

    // count=0: immediate seq_done, never busy, no engine activity.
    s0 = start_cnt;
    d0 = done_cnt;
    run_seq(32'd5, 0, 2'd0, 2'd0);
    sample_tick();
    chk("cnt0_seq_done", 32'(seq_done), 32'd1);
    chk("cnt0_busy", 32'(busy), 32'd0);
    repeat (5) sample_tick();
    chk("cnt0_busy_later", 32'(busy), 32'd0);
    chk("cnt0_no_start", 32'(start_cnt - s0), 32'd0);
    chk("cnt0_one_done", 32'(done_cnt - d0), 32'd1);

    // k wraps from 0xFFFFFFFF to 0.
    acc.delete();
    run_seq(32'hFFFF_FFFF, 2, 2'd0, 2'd1);
    wait_idle(200);
    chk("pairs_wrap", 32'(acc.size()), 32'd2);
    if (acc.size() >= 2) begin
      chk("wrap_k0", acc[0].k, 32'hFFFF_FFFF);
      chk("wrap_x0", acc[0].x, 32'h0000_FFFF);
      chk("wrap_k1", acc[1].k, 32'd0);
      chk("wrap_x1", acc[1].x, 32'd0);
      chk("wrap_y1", acc[1].y, 32'd0);
    end

    // Bases 5/7, three pairs.
    acc.delete();
    run_seq(32'd3, 3, 2'd2, 2'd3);
    wait_idle(300);
    chk("pairs_b57", 32'(acc.size()), 32'd3);
    if (acc.size() >= 1) chk("lit_b5_k3", acc[0].x, 32'h0000_9999);

    // Abort in WAIT0: drain the engine, then a fresh run is clean.
    lat = 10;
    acc.delete();
    s0 = start_cnt;
    d0 = done_cnt;
    e0 = eng_done_cnt;
    run_seq(32'd1, 1, 2'd0, 2'd1);
    for (int i = 0; i < 20; i++) begin
      if (start_cnt > s0) break;
      sample_tick();
    end
    chk("abort_start_seen", 32'(start_cnt - s0), 32'd1);
    drive_tick();
    abort = 1'b1;
    drive_tick();
    abort = 1'b0;
    expq.delete();
    sample_tick();
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_no_done_yet", 32'(done_cnt - d0), 32'd0);
    for (int i = 0; i < 50; i++) begin
      if (done_cnt > d0) break;
      sample_tick();
    end
    chk("drain_done_pulse", 32'(done_cnt - d0), 32'd1);
    chk("drain_eng_done_seen", 32'(eng_done_cnt - e0), 32'd1);
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_no_output", 32'(acc.size()), 32'd0);
    lat = 3;
    run_seq(32'd1, 1, 2'd0, 2'd1);
    wait_idle(200);
    chk("post_abort_pairs", 32'(acc.size()), 32'd1);
    if (acc.size() >= 1) begin
      chk("post_abort_x", acc[0].x, 32'h0000_8000);
      chk("post_abort_y", acc[0].y, 32'h0000_5555);
    end

`ifdef VDC_SCHED_TIMEOUT_EN
    // Engine that never answers: watchdog sets error, a new run clears it.
    never_done = 1'b1;
    d0 = done_cnt;
    run_seq(32'd1, 1, 2'd0, 2'd1);
    for (int i = 0; i < int'(TO) + 50; i++) begin
      if (done_cnt > d0) break;
      sample_tick();
    end
    chk("to_done_pulse", 32'(done_cnt - d0), 32'd1);
    chk("to_error", 32'(error), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    expq.delete();
    never_done = 1'b0;
    run_seq(32'd2, 0, 2'd0, 2'd0);
    sample_tick();
    chk("to_error_cleared", 32'(error), 32'd0);
`endif

    repeat (3) sample_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

endmodule
